// File: rtl/sp_ram_ctrl_pkg.sv
// Shared types and constants for the single-port RAM controller.
// Defines the FSM state encoding and default geometry.
package sp_ram_ctrl_pkg;

    localparam int ADDR_W_DEF   = 4;
    localparam int DATA_W_DEF   = 8;
    localparam int WR_PULSE_DEF = 1;
    localparam int DEPTH        = 1 << ADDR_W_DEF;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_SETUP  = 3'd1,
        WR_PULSE  = 3'd2,
        WR_HOLD   = 3'd3,
        RD_ACCESS = 3'd4,
        RD_CAPT   = 3'd5,
        RSP_WAIT  = 3'd6,
        INIT      = 3'd7
    } state_e;

    // Highest legal address for a given address width.
    function automatic int last_addr(input int aw);
        return (1 << aw) - 1;
    endfunction

    // True for the states in which the controller owns the data bus.
    function automatic logic is_wr_state(input state_e s);
        return (s == WR_SETUP) || (s == WR_PULSE) || (s == WR_HOLD);
    endfunction

endpackage

// File: rtl/sp_ram_bus_drv.sv
// Tristate driver for the RAM data bus; the only driver of ram_data.
// The bus floats whenever reset is asserted, regardless of drive_en.
module sp_ram_bus_drv #(
    parameter int DATA_W = 8
) (
    input  logic              rstn_in,
    input  logic              drive_en,
    input  logic [DATA_W-1:0] data,
    inout  wire  [DATA_W-1:0] bus
);

    assign bus = (rstn_in && drive_en) ? data : {DATA_W{1'bz}};

endmodule

// File: rtl/sp_ram_ctrl.sv
// Request/response controller for a 16x8 asynchronous single-port RAM.
// Optional macro SP_RAM_CTRL_INIT_EN zero-fills the RAM after reset.
module sp_ram_ctrl
    import sp_ram_ctrl_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int WR_PULSE_CYC = WR_PULSE_DEF
) (
    input  logic              clk_in,
    input  logic              rstn_in,
    input  logic              req_valid_in,
    output logic              req_ready_out,
    input  logic              req_write_in,
    input  logic [ADDR_W-1:0] req_addr_in,
    input  logic [DATA_W-1:0] req_wdata_in,
    output logic              rsp_valid_out,
    input  logic              rsp_ready_in,
    output logic [DATA_W-1:0] rsp_rdata_out,
    output logic              ram_write_out,
    output logic              ram_enable_out,
    output logic [ADDR_W-1:0] ram_addr_out,
    inout  wire  [DATA_W-1:0] ram_data,
    output logic              busy_out
);

    localparam int CNT_W = $clog2(WR_PULSE_CYC + 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(WR_PULSE_CYC);

`ifdef SP_RAM_CTRL_INIT_EN
    localparam state_e RST_STATE = INIT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(last_addr(ADDR_W));
`else
    localparam state_e RST_STATE = IDLE;
`endif

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] wdata_d;
    logic [CNT_W-1:0]  pulse_q;
    logic [CNT_W-1:0]  pulse_d;

`ifdef SP_RAM_CTRL_INIT_EN
    logic              init_q;
    logic              init_d;
`endif

    logic              ready_q;
    logic              busy_q;
    logic              write_q;
    logic              enable_q;
    logic              drive_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rdata_q;

    logic              ready_d;
    logic              busy_d;
    logic              write_d;
    logic              enable_d;
    logic              drive_d;
    logic              rsp_valid_d;

    logic              accept;

    // ready_q is only ever high while sitting in IDLE
    assign accept = req_valid_in && ready_q;

    // State and captured-request registers
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            state_q <= RST_STATE;
            addr_q  <= '0;
            wdata_q <= '0;
            pulse_q <= '0;
`ifdef SP_RAM_CTRL_INIT_EN
            init_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pulse_q <= pulse_d;
`ifdef SP_RAM_CTRL_INIT_EN
            init_q  <= init_d;
`endif
        end
    end

    // Next-state logic and request capture
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pulse_d = pulse_q;
`ifdef SP_RAM_CTRL_INIT_EN
        init_d  = init_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = req_addr_in;
                    wdata_d = req_wdata_in;
                    state_d = req_write_in ? WR_SETUP : RD_ACCESS;
                end
            end
            WR_SETUP: begin
                pulse_d = CNT_W'(1);
                state_d = WR_PULSE;
            end
            WR_PULSE: begin
                if (pulse_q == PULSE_LAST) begin
                    state_d = WR_HOLD;
                end else begin
                    pulse_d = pulse_q + CNT_W'(1);
                end
            end
            WR_HOLD: begin
                state_d = IDLE;
`ifdef SP_RAM_CTRL_INIT_EN
                if (init_q) begin
                    if (addr_q == LAST_ADDR) begin
                        init_d = 1'b0;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = WR_SETUP;
                    end
                end
`endif
            end
            RD_ACCESS: begin
                state_d = RD_CAPT;
            end
            RD_CAPT: begin
                state_d = RSP_WAIT;
            end
            RSP_WAIT: begin
                if (rsp_ready_in) begin
                    state_d = IDLE;
                end
            end
            INIT: begin
                addr_d  = '0;
                wdata_d = '0;
                state_d = WR_SETUP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the next state, so every output is a flop
    always_comb begin
        ready_d     = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        write_d     = (state_d == WR_PULSE);
        enable_d    = (state_d == RD_ACCESS) || (state_d == RD_CAPT);
        drive_d     = is_wr_state(state_d);
        rsp_valid_d = (state_d == RSP_WAIT);
    end

    // Registered outputs and read-data capture
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            write_q     <= 1'b0;
            enable_q    <= 1'b0;
            drive_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            write_q     <= write_d;
            enable_q    <= enable_d;
            drive_q     <= drive_d;
            rsp_valid_q <= rsp_valid_d;
            if (state_q == RD_CAPT) begin
                rdata_q <= ram_data;
            end
        end
    end

    sp_ram_bus_drv #(
        .DATA_W (DATA_W)
    ) u_bus_drv (
        .rstn_in  (rstn_in),
        .drive_en (drive_q),
        .data     (wdata_q),
        .bus      (ram_data)
    );

    assign req_ready_out  = ready_q;
    assign busy_out       = busy_q;
    assign ram_write_out  = write_q;
    assign ram_enable_out = enable_q;
    assign ram_addr_out   = addr_q;
    assign rsp_valid_out  = rsp_valid_q;
    assign rsp_rdata_out  = rdata_q;

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Self-checking bench for sp_ram_ctrl with a behavioural RAM and
// reference memory model; table vectors, corner sequences, random ops.
module tb_sp_ram_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int P  = 1;
`ifdef SP_RAM_CTRL_INIT_EN
    localparam int EXP_RDY = 1 + 16 * (2 + P);
`else
    localparam int EXP_RDY = 1;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_ready = 1'b0;
    wire           req_ready;
    wire           rsp_valid;
    wire  [DW-1:0] rsp_rdata;
    wire           ram_write;
    wire           ram_enable;
    wire  [AW-1:0] ram_addr;
    wire  [DW-1:0] ram_data;
    wire           busy;

    int checks = 0;
    int passed = 0;

    logic [DW-1:0] ref_mem [16];
    logic          ref_ok  [16];

    logic [DW-1:0] mem [16];

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t tbl [8];

    sp_ram_ctrl dut (
        .clk_in         (clk),
        .rstn_in        (rstn),
        .req_valid_in   (req_valid),
        .req_ready_out  (req_ready),
        .req_write_in   (req_write),
        .req_addr_in    (req_addr),
        .req_wdata_in   (req_wdata),
        .rsp_valid_out  (rsp_valid),
        .rsp_ready_in   (rsp_ready),
        .rsp_rdata_out  (rsp_rdata),
        .ram_write_out  (ram_write),
        .ram_enable_out (ram_enable),
        .ram_addr_out   (ram_addr),
        .ram_data       (ram_data),
        .busy_out       (busy)
    );

    always #5 clk = ~clk;

    // Asynchronous RAM model: drives the bus on reads, stores on strobe
    assign ram_data = (ram_enable && !ram_write) ? mem[ram_addr] : 8'bz;

    always @(posedge clk) begin
        if (ram_write) mem[ram_addr] <= ram_data;
    end

    int viol = 0;
    int bad_w = 0;
    int run = 0;

    // Protocol watch: no strobe/enable overlap, ready only when idle,
    // strobe width exactly P cycles
    always @(negedge clk) begin
        if (!rstn) begin
            run = 0;
        end else begin
            if (ram_write && ram_enable) viol++;
            if (req_ready && busy) viol++;
            if (ram_write) begin
                run++;
            end else if (run != 0) begin
                if (run != P) bad_w++;
                run = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
`ifdef SP_RAM_CTRL_INIT_EN
            ref_mem[i] = 8'h00;
            ref_ok[i]  = 1'b1;
`else
            ref_ok[i]  = 1'b0;
`endif
        end
    endtask

    // Called just after releasing reset between a negedge and posedge
    task automatic after_reset();
        int n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_after_reset", n, EXP_RDY);
        check("busy_after_reset", busy, 0);
        model_reset();
    endtask

    task automatic issue(input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        int n = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", n < 200, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 4'($urandom);
        req_wdata = 8'($urandom);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int k = 0;
        issue(1'b1, a, d);
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("wr_latency", k, 2 + P);
        ref_mem[a] = d;
        ref_ok[a]  = 1'b1;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int delay,
                           input logic [DW-1:0] exp);
        int k = 0;
        rsp_ready = (delay == 0);
        issue(1'b0, a, 8'($urandom));
        while (!rsp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("rd_latency", k, 2);
        check("rd_data", rsp_rdata, exp);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check("rsp_hold_valid", rsp_valid, 1);
            check("rsp_hold_data", rsp_rdata, exp);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("rsp_done", rsp_valid, 0);
        check("ready_after_rsp", req_ready, 1);
        rsp_ready = 1'b0;
    endtask

    initial begin
        int k;
        logic [DW-1:0] d;
        logic [AW-1:0] a;

        tbl[0] = '{1'b1, 4'h3, 8'hA5, 8'h00};
        tbl[1] = '{1'b0, 4'h3, 8'h00, 8'hA5};
        tbl[2] = '{1'b1, 4'h9, 8'h5A, 8'h00};
        tbl[3] = '{1'b1, 4'h3, 8'hC3, 8'h00};
        tbl[4] = '{1'b0, 4'h9, 8'h00, 8'h5A};
        tbl[5] = '{1'b0, 4'h3, 8'h00, 8'hC3};
        tbl[6] = '{1'b1, 4'hF, 8'h01, 8'h00};
        tbl[7] = '{1'b0, 4'hF, 8'h00, 8'h01};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_write", ram_write, 0);
        check("rst_enable", ram_enable, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_busy", busy, 0);
        #2 rstn = 1'b1;
        after_reset();
        check("idle_write", ram_write, 0);
        check("idle_enable", ram_enable, 0);
`ifdef SP_RAM_CTRL_INIT_EN
        do_read(4'h7, 0, 8'h00);
`else
        check("idle_addr", ram_addr, 0);
`endif

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].w) do_write(tbl[i].a, tbl[i].d);
            else do_read(tbl[i].a, 0, tbl[i].exp);
        end

        // Full sweep, data = addr ^ F0
        for (int i = 0; i < 16; i++) do_write(4'(i), 8'(i) ^ 8'hF0);
        for (int i = 0; i < 16; i++) do_read(4'(i), 0, 8'(i) ^ 8'hF0);

        // Response back-pressure with a new request held pending
        rsp_ready = 1'b0;
        issue(1'b0, 4'h9, 8'h00);
        k = 0;
        while (!rsp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("bp_latency", k, 2);
        check("bp_data", rsp_rdata, ref_mem[9]);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 4'h9;
        req_wdata = 8'h11;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", rsp_valid, 1);
            check("bp_hold", rsp_rdata, ref_mem[9]);
            check("bp_not_ready", req_ready, 0);
            check("bp_no_write", ram_write, 0);
        end
        rsp_ready = 1'b1;
        do_write(4'h9, 8'h11);
        rsp_ready = 1'b0;
        do_read(4'h9, 0, 8'h11);

        // Changing request while busy: only the accepted value is used
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 4'h2;
        req_wdata = 8'h77;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        @(negedge clk);
        k = 0;
        while (!req_ready && k < 20) begin
            check("busy_addr", ram_addr, 4'h2);
            if (ram_write) check("busy_bus", ram_data, 8'h77);
            req_addr  = 4'($urandom);
            req_wdata = 8'($urandom);
            @(negedge clk);
            k++;
        end
        check("busy_len", k, 2 + P);
        req_addr  = 4'hE;
        req_wdata = 8'h42;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("second_accepted", busy, 1);
        check("second_addr", ram_addr, 4'hE);
        ref_mem[2]  = 8'h77;
        ref_ok[2]   = 1'b1;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("second_latency", k, 2 + P);
        ref_mem[14] = 8'h42;
        ref_ok[14]  = 1'b1;
        do_read(4'h2, 0, 8'h77);
        do_read(4'hE, 1, 8'h42);

        // Reset during the write strobe
        issue(1'b1, 4'h5, 8'h99);
        check("setup_no_strobe", ram_write, 0);
        check("setup_bus", ram_data, 8'h99);
        @(negedge clk);
        check("pulse_strobe", ram_write, 1);
        check("pulse_bus", ram_data, 8'h99);
        #1 rstn = 1'b0;
        #1;
        check("rstw_write", ram_write, 0);
        check("rstw_enable", ram_enable, 0);
        check("rstw_busy", busy, 0);
        check("rstw_ready", req_ready, 0);
        @(negedge clk);
        #2 rstn = 1'b1;
        after_reset();
        do_write(4'h5, 8'h3C);
        do_read(4'h5, 0, 8'h3C);

        // Reset during a read: response dropped
        issue(1'b0, 4'h5, 8'h00);
        @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        check("rstr_valid", rsp_valid, 0);
        check("rstr_enable", ram_enable, 0);
        check("rstr_rdata", rsp_rdata, 0);
        @(negedge clk);
        #2 rstn = 1'b1;
        after_reset();
        check("rstr_no_rsp", rsp_valid, 0);

        // Random traffic against the reference memory
        for (int i = 0; i < 60; i++) begin
            a = 4'($urandom);
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 1 || !ref_ok[a]) do_write(a, d);
            else do_read(a, $urandom_range(0, 3), ref_mem[a]);
        end

        check("strobe_enable_overlap", viol, 0);
        check("strobe_width", bad_w, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
